ac_register_bank: RTL and testbench
===================================

Name: ac_register_bank

Overview:
Parametrised, multi-channel successor to the single 24-bit accumulator register in the matrix-multiplication datapath. Holds NUM_CH independent accumulators. Each cycle, one accumulator selected by ch_sel may be loaded from the bus, loaded from the ALU, incremented or decremented, or cleared. Provides a registered read of the selected channel, per-channel zero flags and sticky overflow flags, so the controller can keep several partial sums (one per output column) without spilling them to memory.

Parameters:
WORD_SIZE, 24, accumulator width in bits (>=2)
NUM_CH, 4, number of accumulator channels (>=1)
SEL_W, $clog2(NUM_CH) (min 1), channel-select width; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
ch_sel  in  SEL_W  channel addressed by this cycle's operation
write_en  in  1  load data_in into ch_sel
data_in  in  WORD_SIZE  bus load value
alu_to_ac  in  1  load alu_out into ch_sel
alu_out  in  WORD_SIZE  ALU result
incre  in  1  ch_sel <= ch_sel + 1
decre  in  1  ch_sel <= ch_sel - 1
clr  in  1  ch_sel <= 0, clears that channel's overflow flag
clr_all  in  1  all channels <= 0, all flags cleared
data_out  out  WORD_SIZE  registered copy of ac[ch_sel] after this cycle's update
zero  out  NUM_CH  zero[i]=1 when ac[i]==0 (combinational from the registers)
ovf  out  NUM_CH  sticky wrap/saturation flag per channel

Behaviour:
- Reset: when rst=1 at a clk edge, all ac[i]=0, data_out=0, ovf=0, and zero becomes all-ones. rst overrides every other input.
- One operation per cycle on ch_sel, fixed priority: clr_all > clr > alu_to_ac > write_en > incre/decre. Lower-priority requests in the same cycle are dropped, not queued.
- incre and decre both asserted: they cancel, no change. ovf is not touched.
- Increment at all-ones wraps to 0 and sets ovf[ch_sel]. Decrement at 0 wraps to all-ones and sets ovf[ch_sel].
- Loads (write_en, alu_to_ac) never change ovf. ovf[i] clears only on rst, clr_all, or clr while ch_sel==i.
- ch_sel >= NUM_CH (non-power-of-2 NUM_CH): the operation is ignored and data_out=0.
- data_out latency is 1 cycle. On edge k, data_out takes the value ac[ch_sel] holds after edge k's update, so a read-after-write to the same channel returns the new value with no bubble.
- Unselected channels hold their value, except under clr_all.
- Increment and decrement arithmetic is modulo 2^WORD_SIZE (unsigned) unless AC_SAT_EN is defined.

Optional Feature:
AC_SAT_EN
- Defined: incre at all-ones holds all-ones, and decre at 0 holds 0. Both still set ovf[ch_sel].
- Undefined: wrap-around as above.
- Load paths are identical in both builds.

Decomposition:
- Shared package ac_pkg holds:
  - the op-code enum {OP_NONE, OP_CLR, OP_ALU, OP_LOAD, OP_INC, OP_DEC}
  - the default WORD_SIZE=24 constant
  - the priority encoder function that turns the control bits into an op-code
- Sub-module ac_channel, instanced NUM_CH times. Each instance takes the decoded op, a select-match bit, the load value and clr_all, and holds its own accumulator and ovf bit.
- Top level does decode, data_out muxing and zero-flag generation.

Test Plan:
- Reset: preload ch0..ch3=5,6,7,8, then rst=1 for 1 cycle -> all channels 0, data_out=0, zero=4'b1111, ovf=0. rst together with write_en -> still all 0.
- Channel isolation: write_en ch_sel=2 data_in=24'h00ABCD -> next cycle data_out=24'h00ABCD. Reading ch0,1,3 returns 0. zero=4'b1011.
- Priority: ch_sel=1 with alu_to_ac=1 alu_out=24'h000010, write_en=1 data_in=24'h000020 and incre=1 all at once -> ac[1]=24'h000010. Same cycle with clr=1 -> ac[1]=0.
- Wrap (no AC_SAT_EN): load 24'hFFFFFF into ch3, incre -> ac[3]=0, ovf[3]=1. A later load of 24'h5 leaves ovf[3]=1. clr on ch3 -> ovf[3]=0.
- Saturate (AC_SAT_EN defined): ch0=0, decre -> ac[0]=0, ovf[0]=1. ch0=24'hFFFFFF, incre -> stays 24'hFFFFFF.
- Inc/dec cancel and clr_all: ch2=7 with incre=decre=1 -> stays 7. clr_all with write_en on ch2 -> every channel 0 and ovf all 0.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared definitions for the multi-channel accumulator bank: operation codes,
// the default accumulator width and the control-bit priority encoder.
package ac_pkg;

    localparam int AC_WORD_SIZE = 24;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CLR  = 3'd1,
        OP_ALU  = 3'd2,
        OP_LOAD = 3'd3,
        OP_INC  = 3'd4,
        OP_DEC  = 3'd5
    } ac_op_e;

    // Fixed priority clr > alu_to_ac > write_en > incre/decre. clr_all is
    // broadcast to every channel separately and outranks all of these.
    // incre together with decre cancels out to no operation.
    function automatic ac_op_e ac_decode(input logic clr,
                                         input logic alu_to_ac,
                                         input logic write_en,
                                         input logic incre,
                                         input logic decre);
        ac_op_e op;
        op = OP_NONE;
        if (clr)                 op = OP_CLR;
        else if (alu_to_ac)      op = OP_ALU;
        else if (write_en)       op = OP_LOAD;
        else if (incre && !decre) op = OP_INC;
        else if (decre && !incre) op = OP_DEC;
        return op;
    endfunction

endpackage

// File: rtl/ac_channel.sv
// One accumulator channel: holds the accumulator word and its sticky overflow
// flag, applying the decoded operation only when this channel is selected.
// Build option: define AC_SAT_EN to saturate inc/dec instead of wrapping.
module ac_channel
    import ac_pkg::*;
#(
    parameter int WORD_SIZE = AC_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  ac_op_e               op_i,
    input  logic                 sel_i,
    input  logic [WORD_SIZE-1:0] load_i,
    input  logic                 clr_all_i,
    output logic [WORD_SIZE-1:0] ac_o,
    output logic [WORD_SIZE-1:0] ac_d_o,
    output logic                 ovf_o
);

    localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    logic [WORD_SIZE-1:0] ac_q, ac_d;
    logic                 ovf_q, ovf_d;

    // Increment; returns {overflow, result}. All-ones either wraps or holds.
    function automatic logic [WORD_SIZE:0] step_up(input logic [WORD_SIZE-1:0] v);
        if (&v) begin
`ifdef AC_SAT_EN
            return {1'b1, v};
`else
            return {1'b1, {WORD_SIZE{1'b0}}};
`endif
        end
        return {1'b0, v + ONE};
    endfunction

    // Decrement; returns {overflow, result}. Zero either wraps or holds.
    function automatic logic [WORD_SIZE:0] step_down(input logic [WORD_SIZE-1:0] v);
        if (v == '0) begin
`ifdef AC_SAT_EN
            return {1'b1, v};
`else
            return {1'b1, {WORD_SIZE{1'b1}}};
`endif
        end
        return {1'b0, v - ONE};
    endfunction

    // Next-state: clr_all wins everywhere, otherwise only the selected channel moves.
    always_comb begin
        logic [WORD_SIZE:0] step;
        ac_d  = ac_q;
        ovf_d = ovf_q;
        step  = '0;
        if (clr_all_i) begin
            ac_d  = '0;
            ovf_d = 1'b0;
        end else if (sel_i) begin
            case (op_i)
                OP_CLR: begin
                    ac_d  = '0;
                    ovf_d = 1'b0;
                end
                OP_ALU, OP_LOAD: ac_d = load_i;
                OP_INC: begin
                    step  = step_up(ac_q);
                    ac_d  = step[WORD_SIZE-1:0];
                    ovf_d = ovf_q | step[WORD_SIZE];
                end
                OP_DEC: begin
                    step  = step_down(ac_q);
                    ac_d  = step[WORD_SIZE-1:0];
                    ovf_d = ovf_q | step[WORD_SIZE];
                end
                default: ;
            endcase
        end
    end

    // Accumulator and overflow state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            ac_q  <= ac_d;
            ovf_q <= ovf_d;
        end
    end

    assign ac_o   = ac_q;
    assign ac_d_o = ac_d;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/ac_register_bank.sv
// Multi-channel accumulator bank: decodes the per-cycle operation, steers it
// to the channel addressed by ch_sel, provides a registered read of that
// channel's post-update value, and per-channel zero and sticky overflow flags.
// Build option: define AC_SAT_EN for saturating increment/decrement.
module ac_register_bank
    import ac_pkg::*;
#(
    parameter  int WORD_SIZE = AC_WORD_SIZE,
    parameter  int NUM_CH    = 4,
    localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_W-1:0]     ch_sel,
    input  logic                 write_en,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 alu_to_ac,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 incre,
    input  logic                 decre,
    input  logic                 clr,
    input  logic                 clr_all,
    output logic [WORD_SIZE-1:0] data_out,
    output logic [NUM_CH-1:0]    zero,
    output logic [NUM_CH-1:0]    ovf
);

    ac_op_e               op;
    logic [WORD_SIZE-1:0] load_val;
    logic [NUM_CH-1:0]    sel_match;
    logic [WORD_SIZE-1:0] ac_w   [NUM_CH];
    logic [WORD_SIZE-1:0] ac_d_w [NUM_CH];
    logic [WORD_SIZE-1:0] data_out_q, data_out_d;

    assign op       = ac_decode(clr, alu_to_ac, write_en, incre, decre);
    assign load_val = (op == OP_ALU) ? alu_out : data_in;

    // One-hot channel select; an out-of-range ch_sel matches no channel.
    always_comb begin
        sel_match = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_match[i] = (ch_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ac_channel #(.WORD_SIZE(WORD_SIZE)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .op_i      (op),
            .sel_i     (sel_match[g]),
            .load_i    (load_val),
            .clr_all_i (clr_all),
            .ac_o      (ac_w[g]),
            .ac_d_o    (ac_d_w[g]),
            .ovf_o     (ovf[g])
        );
        assign zero[g] = (ac_w[g] == '0);
    end

    // Read mux taps the channel next-state so read-after-write has no bubble.
    always_comb begin
        data_out_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_match[i]) data_out_d = ac_d_w[i];
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) data_out_q <= '0;
        else     data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_ac_register_bank.sv
// Directed self-checking bench for ac_register_bank (NUM_CH=4, WORD_SIZE=24).
// Expected values follow the AC_SAT_EN setting of the build.
module tb_ac_register_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_sel;
    logic        write_en;
    logic [23:0] data_in;
    logic        alu_to_ac;
    logic [23:0] alu_out;
    logic        incre;
    logic        decre;
    logic        clr;
    logic        clr_all;
    logic [23:0] data_out;
    logic [3:0]  zero;
    logic [3:0]  ovf;

    int n_checks = 0;
    int n_errors = 0;

    ac_register_bank #(.WORD_SIZE(24), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_sel    (ch_sel),
        .write_en  (write_en),
        .data_in   (data_in),
        .alu_to_ac (alu_to_ac),
        .alu_out   (alu_out),
        .incre     (incre),
        .decre     (decre),
        .clr       (clr),
        .clr_all   (clr_all),
        .data_out  (data_out),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 0; write_en = 0; data_in = '0; alu_to_ac = 0; alu_out = '0;
        incre = 0; decre = 0; clr = 0; clr_all = 0;
    endtask

    // Apply the currently driven inputs for one clock edge, then return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [1:0] ch, input logic [23:0] v);
        ch_sel = ch; write_en = 1; data_in = v;
        tick();
    endtask

    task automatic rd(input logic [1:0] ch);
        ch_sel = ch;
        tick();
    endtask

    initial begin
        ch_sel = 0;
        idle();
        rst = 1;
        tick();
        chk("reset_data", data_out, 0);
        chk("reset_zero", zero, 4'b1111);
        chk("reset_ovf", ovf, 0);

        // Preload and reset again, with a write in the reset cycle.
        wr(0, 5); wr(1, 6); wr(2, 7); wr(3, 8);
        chk("preload_data", data_out, 8);
        chk("preload_zero", zero, 4'b0000);
        ch_sel = 1; write_en = 1; data_in = 24'h9; rst = 1;
        tick();
        chk("rst_wr_data", data_out, 0);
        chk("rst_wr_zero", zero, 4'b1111);
        chk("rst_wr_ovf", ovf, 0);
        rd(1);
        chk("rst_wr_ch1", data_out, 0);

        // Channel isolation.
        wr(2, 24'h00ABCD);
        chk("iso_ch2", data_out, 24'h00ABCD);
        rd(0); chk("iso_ch0", data_out, 0);
        rd(1); chk("iso_ch1", data_out, 0);
        rd(3); chk("iso_ch3", data_out, 0);
        chk("iso_zero", zero, 4'b1011);

        // Priority.
        ch_sel = 1; alu_to_ac = 1; alu_out = 24'h10; write_en = 1; data_in = 24'h20; incre = 1;
        tick();
        chk("prio_alu", data_out, 24'h10);
        ch_sel = 1; alu_to_ac = 1; alu_out = 24'h10; write_en = 1; data_in = 24'h20; incre = 1; clr = 1;
        tick();
        chk("prio_clr", data_out, 0);
        chk("prio_zero", zero, 4'b1011);

        // All-ones increment on ch3.
        wr(3, 24'hFFFFFF);
        ch_sel = 3; incre = 1;
        tick();
`ifdef AC_SAT_EN
        chk("inc_top_data", data_out, 24'hFFFFFF);
`else
        chk("inc_top_data", data_out, 0);
`endif
        chk("inc_top_ovf", ovf, 4'b1000);
        wr(3, 24'h5);
        chk("load_keep_data", data_out, 24'h5);
        chk("load_keep_ovf", ovf, 4'b1000);
        ch_sel = 3; clr = 1;
        tick();
        chk("clr_ovf", ovf, 4'b0000);
        chk("clr_data", data_out, 0);

        // Zero decrement on ch0.
        ch_sel = 0; decre = 1;
        tick();
`ifdef AC_SAT_EN
        chk("dec_bot_data", data_out, 0);
`else
        chk("dec_bot_data", data_out, 24'hFFFFFF);
`endif
        chk("dec_bot_ovf", ovf, 4'b0001);

        // Ordinary increment and decrement leave ovf alone.
        ch_sel = 1; incre = 1;
        tick();
        chk("inc_plain", data_out, 1);
        chk("inc_plain_ovf", ovf, 4'b0001);

        // Cancel, plain decrement, then clr_all with a write.
        wr(2, 7);
        ch_sel = 2; incre = 1; decre = 1;
        tick();
        chk("cancel_data", data_out, 7);
        chk("cancel_ovf", ovf, 4'b0001);
        ch_sel = 2; decre = 1;
        tick();
        chk("dec_plain", data_out, 6);
        ch_sel = 2; write_en = 1; data_in = 24'h9; clr_all = 1;
        tick();
        chk("clrall_data", data_out, 0);
        chk("clrall_zero", zero, 4'b1111);
        chk("clrall_ovf", ovf, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
